count_event_monitor: RTL and testbench

//  Downstream stage of the loadable up/down counter: samples its count and opnd every clk.

---
 rtl/count_event_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_count_event_monitor.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// ---------------------------------------------------------------------------
// count_event_monitor
//
// Purpose
//   Sits downstream of the loadable up/down counter and samples its count and
//   direction (opnd) every clock. It detects two kinds of event:
//     - wrap-around: the counter passing its terminal value in the current
//       direction (MAX->0 counting up, 0->MAX counting down);
//     - compare match: count reaching cmp_val while detection is armed.
//   Each event raises a registered 1-cycle pulse. Events are accumulated in a
//   saturating counter with sticky "any event" and "event lost" flags that
//   stay set until software pulses evt_clr. The outputs feed the
//   interrupt/status logic.
//
// Parameters
//   CW     width of the monitored count bus; terminal value MAX = 2**CW-1
//   EVT_W  width of the saturating event counter; saturates at 2**EVT_W-1
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   count        in   CW     counter value, [0:CW-1], bit 0 = MSB
//   opnd         in   1      counter direction: 1 = up, 0 = down
//   cmp_en       in   1      arms compare-match detection
//   cmp_val      in   CW     compare value, [0:CW-1]
//   evt_clr      in   1      1-cycle request: clear evt_cnt, evt_flag, evt_ovf
//   match_pulse  out  1      1-cycle pulse on a compare match
//   wrap_pulse   out  1      1-cycle pulse on a wrap-around
//   evt_flag     out  1      sticky: any event since the last clear
//   evt_ovf      out  1      sticky: an event was lost at saturation
//   evt_cnt      out  EVT_W  saturating event count
//   cap_val      out  CW     (COUNT_MON_CAPTURE_EN only) count captured at the
//                            most recent match or wrap
//   dbg_state    out  2      match FSM state: 0 = IDLE, 1 = ARMED, 2 = HIT
//
// Configuration
//   COUNT_MON_CAPTURE_EN  when defined, adds the cap_val port and its capture
//                         register. When undefined, neither exists and all
//                         other behaviour is unchanged.
//
// Timing
//   The edge that samples a count showing an event also loads the pulse
//   register, so the pulse is high for the clock cycle following that edge.
//   evt_cnt/evt_flag/evt_ovf (and cap_val) update on that same edge.
// ---------------------------------------------------------------------------
module count_event_monitor #(
  parameter int CW    = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:CW-1]    count,
  input  logic             opnd,
  input  logic             cmp_en,
  input  logic [0:CW-1]    cmp_val,
  input  logic             evt_clr,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic             evt_flag,
  output logic             evt_ovf,
  output logic [EVT_W-1:0] evt_cnt,
`ifdef COUNT_MON_CAPTURE_EN
  output logic [0:CW-1]    cap_val,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [0:CW-1]    CNT_MAX  = '1;
  localparam logic [0:CW-1]    CNT_ZERO = '0;
  localparam logic [EVT_W-1:0] EVT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [0:CW-1] prev_cnt;
  logic          prev_vld;
  // Set once ARMED has seen at least one sample; cleared on every entry to
  // ARMED so a count that already equals cmp_val when arming still matches.
  logic          prev_vld_armed;

  logic          wrap_det;
  logic          match_det;
  logic [EVT_W:0] evt_sum;
  logic          evt_sat;

  // -------------------------------------------------------------------------
  // Event detection (combinational, registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    wrap_det = 1'b0;
    if (prev_vld) begin
      if (opnd && (prev_cnt == CNT_MAX) && (count == CNT_ZERO)) begin
        wrap_det = 1'b1;
      end
      if (!opnd && (prev_cnt == CNT_ZERO) && (count == CNT_MAX)) begin
        wrap_det = 1'b1;
      end
    end
  end

  // Edge-based match: a count held at cmp_val only matches on arrival, or on
  // the first ARMED sample if it was already there.
  always_comb begin
    match_det = 1'b0;
    if (prev_vld && (state == ARMED) && (count == cmp_val) &&
        ((count != prev_cnt) || !prev_vld_armed)) begin
      match_det = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Match FSM next state. Only match detection is gated by the FSM; wrap
  // detection is always active.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmp_en) state_nxt = ARMED;
      end
      ARMED: begin
        if (!cmp_en)        state_nxt = IDLE;
        else if (match_det) state_nxt = HIT;
      end
      HIT: begin
        if (!cmp_en)                 state_nxt = IDLE;
        else if (count != cmp_val)   state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Event accumulation. The add is one bit wider than the counter so a
  // carry out of EVT_W bits is visible to the saturate check.
  // -------------------------------------------------------------------------
  always_comb begin
    evt_sum = {1'b0, evt_cnt} + {{EVT_W{1'b0}}, match_det}
                              + {{EVT_W{1'b0}}, wrap_det};
    evt_sat = (evt_sum > {1'b0, EVT_MAX});
  end

  // -------------------------------------------------------------------------
  // Sampling, FSM and registered pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      prev_cnt       <= '0;
      prev_vld       <= 1'b0;
      prev_vld_armed <= 1'b0;
      match_pulse    <= 1'b0;
      wrap_pulse     <= 1'b0;
    end else begin
      state          <= state_nxt;
      prev_cnt       <= count;
      prev_vld       <= 1'b1;
      // High only while staying in ARMED; any entry into ARMED clears it.
      prev_vld_armed <= (state == ARMED) && (state_nxt == ARMED);
      match_pulse    <= match_det;
      wrap_pulse     <= wrap_det;
    end
  end

  // -------------------------------------------------------------------------
  // Saturating event counter and sticky flags. evt_clr wins over events in
  // the same cycle: the event is dropped from the count (its pulse still
  // fires from the block above).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_cnt  <= '0;
      evt_flag <= 1'b0;
      evt_ovf  <= 1'b0;
    end else if (evt_clr) begin
      evt_cnt  <= '0;
      evt_flag <= 1'b0;
      evt_ovf  <= 1'b0;
    end else begin
      if (evt_sat) begin
        evt_cnt <= EVT_MAX;
        evt_ovf <= 1'b1;
      end else begin
        evt_cnt <= evt_sum[EVT_W-1:0];
      end
      if (match_det || wrap_det) begin
        evt_flag <= 1'b1;
      end
    end
  end

`ifdef COUNT_MON_CAPTURE_EN
  // Captures the count that caused the event; independent of evt_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_val <= '0;
    end else if (match_det || wrap_det) begin
      cap_val <= count;
    end
  end
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_count_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_event_monitor
//
// Directed bench for count_event_monitor. dut drives the default EVT_W=8
// configuration; dut2 (EVT_W=2, own stimulus) exercises saturation and the
// evt_clr-versus-event priority. Inputs change on the falling edge and
// outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_count_event_monitor;

  // Clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus and observation, main instance
  logic [0:3] count;
  logic       opnd;
  logic       cmp_en;
  logic [0:3] cmp_val;
  logic       evt_clr;
  logic       match_pulse;
  logic       wrap_pulse;
  logic       evt_flag;
  logic       evt_ovf;
  logic [7:0] evt_cnt;
  logic [1:0] dbg_state;
  logic [0:3] cap_val;

  // Second instance with a 2-bit event counter
  logic [0:3] c2_count;
  logic       c2_opnd;
  logic       c2_clr;
  logic       c2_match;
  logic       c2_wrap;
  logic       c2_flag;
  logic       c2_ovf;
  logic [1:0] c2_cnt;
  logic [1:0] c2_state;
  logic [0:3] c2_cap;

  int tests_run;
  int tests_failed;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;

  count_event_monitor #(.CW(4), .EVT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .opnd        (opnd),
    .cmp_en      (cmp_en),
    .cmp_val     (cmp_val),
    .evt_clr     (evt_clr),
    .match_pulse (match_pulse),
    .wrap_pulse  (wrap_pulse),
    .evt_flag    (evt_flag),
    .evt_ovf     (evt_ovf),
    .evt_cnt     (evt_cnt),
`ifdef COUNT_MON_CAPTURE_EN
    .cap_val     (cap_val),
`endif
    .dbg_state   (dbg_state)
  );

  count_event_monitor #(.CW(4), .EVT_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .count       (c2_count),
    .opnd        (c2_opnd),
    .cmp_en      (1'b0),
    .cmp_val     (4'd0),
    .evt_clr     (c2_clr),
    .match_pulse (c2_match),
    .wrap_pulse  (c2_wrap),
    .evt_flag    (c2_flag),
    .evt_ovf     (c2_ovf),
    .evt_cnt     (c2_cnt),
`ifdef COUNT_MON_CAPTURE_EN
    .cap_val     (c2_cap),
`endif
    .dbg_state   (c2_state)
  );

`ifndef COUNT_MON_CAPTURE_EN
  assign cap_val = '0;
  assign c2_cap  = '0;
`endif

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic step(input logic [3:0] v);
    @(negedge clk);
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic [3:0] v);
    @(negedge clk);
    c2_count = v;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Scenario tasks
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({match_pulse, wrap_pulse, evt_flag, evt_ovf} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b want 0000", {match_pulse, wrap_pulse, evt_flag, evt_ovf});
      tests_failed++;
    end
    tests_run++;
    if (evt_cnt !== 8'd0) begin
      $display("FAIL reset_cnt: got %0d want 0", evt_cnt); tests_failed++;
    end
    tests_run++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); tests_failed++;
    end
`ifdef COUNT_MON_CAPTURE_EN
    tests_run++;
    if (cap_val !== 4'd0) begin
      $display("FAIL reset_cap: got %0d want 0", cap_val); tests_failed++;
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    opnd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(4'(i));
      tests_run++;
      if ({match_pulse, wrap_pulse} !== 2'b00) begin
        $display("FAIL up_quiet[%0d]: got %b want 00", i, {match_pulse, wrap_pulse});
        tests_failed++;
      end
    end
    step(4'd0);
    tests_run++;
    if (wrap_pulse !== 1'b1) begin
      $display("FAIL up_wrap: got %b want 1", wrap_pulse); tests_failed++;
    end
    tests_run++;
    if ({evt_cnt, evt_flag, evt_ovf} !== {8'd1, 1'b1, 1'b0}) begin
      $display("FAIL up_wrap_evt: got cnt=%0d flag=%b ovf=%b want 1 1 0", evt_cnt, evt_flag, evt_ovf);
      tests_failed++;
    end
    step(4'd1);
    tests_run++;
    if (wrap_pulse !== 1'b0) begin
      $display("FAIL up_wrap_one_cycle: got %b want 0", wrap_pulse); tests_failed++;
    end
  endtask

  task automatic test_wrap_down();
    opnd = 1'b0;
    step(4'd1);
    step(4'd0);
    tests_run++;
    if (wrap_pulse !== 1'b0) begin
      $display("FAIL down_pre: got %b want 0", wrap_pulse); tests_failed++;
    end
    step(4'd15);
    tests_run++;
    if (wrap_pulse !== 1'b1) begin
      $display("FAIL down_wrap: got %b want 1", wrap_pulse); tests_failed++;
    end
    tests_run++;
    if (evt_cnt !== 8'd2) begin
      $display("FAIL down_cnt: got %0d want 2", evt_cnt); tests_failed++;
    end
`ifdef COUNT_MON_CAPTURE_EN
    tests_run++;
    if (cap_val !== 4'd15) begin
      $display("FAIL down_cap: got %0d want 15", cap_val); tests_failed++;
    end
`endif
    step(4'd5);
    step(4'd9);
    tests_run++;
    if (wrap_pulse !== 1'b0 || evt_cnt !== 8'd2) begin
      $display("FAIL load_jump: got wrap=%b cnt=%0d want 0 2", wrap_pulse, evt_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_match();
    logic [3:0] seq [5];
    logic       exp_m [5];
    logic [1:0] exp_s [5];
    seq   = '{4'd4, 4'd5, 4'd5, 4'd5, 4'd6};
    exp_m = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_s = '{S_ARMED, S_HIT, S_HIT, S_HIT, S_ARMED};
    cmp_val = 4'd5;
    cmp_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(seq[i]);
      tests_run++;
      if (match_pulse !== exp_m[i] || dbg_state !== exp_s[i]) begin
        $display("FAIL match[%0d]: got pulse=%b state=%0d want %b %0d",
                 i, match_pulse, dbg_state, exp_m[i], exp_s[i]);
        tests_failed++;
      end
      if (i == 1) begin
        tests_run++;
        if (evt_cnt !== 8'd3) begin
          $display("FAIL match_cnt: got %0d want 3", evt_cnt); tests_failed++;
        end
      end
    end
`ifdef COUNT_MON_CAPTURE_EN
    tests_run++;
    if (cap_val !== 4'd5) begin
      $display("FAIL match_cap: got %0d want 5", cap_val); tests_failed++;
    end
`endif
  endtask

  task automatic test_match_wrap();
    opnd    = 1'b1;
    cmp_val = 4'd0;
    step(4'd14);
    step(4'd15);
    tests_run++;
    if ({match_pulse, wrap_pulse} !== 2'b00) begin
      $display("FAIL mw_pre: got %b want 00", {match_pulse, wrap_pulse}); tests_failed++;
    end
    step(4'd0);
    tests_run++;
    if ({match_pulse, wrap_pulse} !== 2'b11) begin
      $display("FAIL mw_both: got %b want 11", {match_pulse, wrap_pulse}); tests_failed++;
    end
    tests_run++;
    if (evt_cnt !== 8'd5) begin
      $display("FAIL mw_cnt: got %0d want 5", evt_cnt); tests_failed++;
    end
    cmp_en = 1'b0;
    step(4'd1);
    tests_run++;
    if (dbg_state !== S_IDLE) begin
      $display("FAIL disarm: got %0d want %0d", dbg_state, S_IDLE); tests_failed++;
    end
  endtask

  task automatic test_clear();
    evt_clr = 1'b1;
    step(4'd2);
    evt_clr = 1'b0;
    tests_run++;
    if ({evt_cnt, evt_flag, evt_ovf} !== {8'd0, 1'b0, 1'b0}) begin
      $display("FAIL clear: got cnt=%0d flag=%b ovf=%b want 0 0 0", evt_cnt, evt_flag, evt_ovf);
      tests_failed++;
    end
  endtask

  task automatic test_saturate();
    c2_opnd = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step2(4'd15);
      step2(4'd0);
      tests_run++;
      if (c2_wrap !== 1'b1 || c2_cnt !== ((k > 3) ? 2'd3 : 2'(k)) || c2_ovf !== (k == 4)) begin
        $display("FAIL sat[%0d]: got wrap=%b cnt=%0d ovf=%b want 1 %0d %b",
                 k, c2_wrap, c2_cnt, c2_ovf, (k > 3) ? 3 : k, (k == 4));
        tests_failed++;
      end
    end
    tests_run++;
    if (c2_flag !== 1'b1) begin
      $display("FAIL sat_flag: got %b want 1", c2_flag); tests_failed++;
    end
    step2(4'd15);
    c2_clr = 1'b1;
    step2(4'd0);
    c2_clr = 1'b0;
    tests_run++;
    if ({c2_wrap, c2_cnt, c2_ovf, c2_flag} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
      $display("FAIL clr_priority: got wrap=%b cnt=%0d ovf=%b flag=%b want 1 0 0 0",
               c2_wrap, c2_cnt, c2_ovf, c2_flag);
      tests_failed++;
    end
  endtask

  task automatic test_async_reset();
    opnd = 1'b1;
    step(4'd15);
    step(4'd0);
    tests_run++;
    if (wrap_pulse !== 1'b1 || evt_cnt !== 8'd1) begin
      $display("FAIL pre_rst: got wrap=%b cnt=%0d want 1 1", wrap_pulse, evt_cnt); tests_failed++;
    end
    // Mid-cycle, with the pulse high: outputs must drop without a clock edge.
    rst = 1'b1;
    #1;
    tests_run++;
    if ({wrap_pulse, evt_flag, evt_cnt} !== {1'b0, 1'b0, 8'd0} || dbg_state !== S_IDLE) begin
      $display("FAIL async_rst: got wrap=%b flag=%b cnt=%0d state=%0d want 0 0 0 0",
               wrap_pulse, evt_flag, evt_cnt, dbg_state);
      tests_failed++;
    end
`ifdef COUNT_MON_CAPTURE_EN
    tests_run++;
    if (cap_val !== 4'd0) begin
      $display("FAIL async_rst_cap: got %0d want 0", cap_val); tests_failed++;
    end
`endif
    @(negedge clk);
    count = 4'd15;
    opnd  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // prev_cnt is 0 and down-count 0->15 would be a wrap, but this is the
    // first sample after reset.
    tests_run++;
    if (wrap_pulse !== 1'b0 || evt_cnt !== 8'd0) begin
      $display("FAIL first_sample: got wrap=%b cnt=%0d want 0 0", wrap_pulse, evt_cnt);
      tests_failed++;
    end
    step(4'd0);
    step(4'd15);
    tests_run++;
    if (wrap_pulse !== 1'b1 || evt_cnt !== 8'd1) begin
      $display("FAIL post_rst_wrap: got wrap=%b cnt=%0d want 1 1", wrap_pulse, evt_cnt);
      tests_failed++;
    end
  endtask

  // -------------------------------------------------------------------------
  // Sequence and report
  // -------------------------------------------------------------------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    count    = 4'd0;
    opnd     = 1'b1;
    cmp_en   = 1'b0;
    cmp_val  = 4'd0;
    evt_clr  = 1'b0;
    c2_count = 4'd0;
    c2_opnd  = 1'b1;
    c2_clr   = 1'b0;

    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_match();
    test_match_wrap();
    test_clear();
    test_saturate();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
